lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store initiator driving the dmem port (wmem/rmem/mem_addr/store_data/load_data).
//  Accepts one RV32 load/store per handshake from the execute stage, decodes funct3 and
//  byte offset into dmem lane codes, and returns aligned/extended load data. Sub-word
//  stores use read-modify-write, because dmem zero-fills the unwritten lanes of a word.
// PARAMETERS
//  ADDR_W  12  word-address width forwarded to dmem; mem_addr = {0, req_addr[ADDR_W+1:2]}
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   high only in IDLE; transfer when req_valid & req_ready
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data (rs2)
//  resp_valid      out  1   one-cycle completion pulse, no backpressure
//  resp_err        out  1   valid with resp_valid: misaligned or illegal funct3
//  resp_rdata      out  32  load result, valid with resp_valid (0 for stores/errors)
//  mem_wmem        out  4   dmem byte-lane write code
//  mem_rmem        out  5   dmem read code {signed, lanes[3:0]}
//  mem_addr        out  32  dmem word address
//  mem_store_data  out  32  dmem write data
//  mem_load_data   in   32  dmem combinational read data
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, resp_err, resp_rdata, mem_wmem, mem_rmem, mem_addr,
//   mem_store_data all 0. rst mid-operation aborts; pending RMW write is never issued.
//  Request latched (we, funct3, addr, wdata) on acceptance cycle N; inputs ignored otherwise.
//  Decode: off=addr[1:0]. B: lanes=0001<<off. H: off[0] must be 0, lanes=0011<<off.
//   W: off must be 0, lanes=1111. Load signed bit=~funct3[2] for B/H, 0 for W.
//   Illegal: load funct3 011/11x; store funct3 with bit2 set or 011. Misaligned/illegal -> err.
//  States: IDLE, LOAD, RMW_RD, RMW_WR, STORE, RESP.
//   IDLE  : req_ready=1. Accept -> RESP(err=1) | LOAD | STORE(SW) | RMW_RD(SB/SH).
//   LOAD  : mem_rmem={signed,lanes}, mem_wmem=0; capture mem_load_data -> RESP.
//   RMW_RD: mem_rmem=01111; capture word with lanes replaced by wdata bytes
//           (byte k of lane set takes wdata[8*(k-off)+:8]) -> RMW_WR.
//   RMW_WR: mem_wmem=1111, mem_store_data=merged word -> RESP.
//   STORE : mem_wmem=1111, mem_store_data=wdata -> RESP.
//   RESP  : resp_valid=1 for exactly one cycle -> IDLE.
//  mem_wmem/mem_rmem are 0 in IDLE and RESP; mem_addr held from latch through RESP.
//  Latency (resp_valid cycle): error N+1; load and SW N+2; SB/SH N+3. Throughput: one
//   request per (latency+1) cycles; req_ready low from N+1 until IDLE re-entered.
//  Exactly one dmem write per accepted store; none for loads or errors.
// STRUCTURE
//  lsu_pkg: funct3 constants, state enum, RMEM_*/WMEM_* codes, lane/merge functions.
//  Sub-module lsu_lane_decode (combinational): funct3+off -> lanes, signed, err.
//  lsu_ctrl holds FSM, request latch, merge buffer, response registers.
// TESTING
//  1 mem[4]=0x8899AABB; LB addr 0x12 -> rmem=10100, resp_rdata=0xFFFFFF99 at N+2, err=0.
//  2 same word; LHU addr 0x12 -> rmem=01100, resp_rdata=0x00008899; LW 0x10 -> 0x8899AABB.
//  3 SB addr 0x11 wdata 0x5A -> rmem=01111 at N+1, wmem=1111 data 0x88995ABB at N+2,
//    resp at N+3; re-read word 4 = 0x88995ABB.
//  4 LH addr 0x13 and SW addr 0x12 -> resp_err=1 at N+1, no dmem write, memory unchanged.
//  5 rst high in RMW_RD of an SB -> IDLE next cycle, all outputs 0, word unchanged.
//  6 back-to-back req_valid held high: second request accepted only after RESP (req_ready).

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 codes, FSM states, dmem lane codes and merge helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WMEM_NONE = 4'b0000;
  localparam logic [3:0] WMEM_WORD = 4'b1111;
  localparam logic [4:0] RMEM_NONE = 5'b00000;
  localparam logic [4:0] RMEM_WORD = 5'b01111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_STORE  = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  // Store bytes start at wdata[7:0] and slide up to the first selected lane.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  lanes,
                                             input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] shifted;
    mask    = lane_mask(lanes);
    shifted = wdata << {off, 3'b000};
    return (old_w & ~mask) | (shifted & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_decode.sv
// ============================================================================
// Module  : lsu_lane_decode
// Brief   : funct3 + byte offset -> dmem lane set, sign flag and error flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_lane_decode
  import lsu_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  output logic [3:0] lanes,
  output logic       is_signed,
  output logic       err
);

  always_comb begin
    lanes     = 4'b0000;
    is_signed = 1'b0;
    err       = 1'b0;
    case (funct3)
      F3_B: begin
        lanes     = 4'b0001 << off;
        is_signed = ~we;
      end
      F3_BU: begin
        lanes = 4'b0001 << off;
        err   = we;
      end
      F3_H: begin
        lanes     = 4'b0011 << off;
        is_signed = ~we;
        err       = off[0];
      end
      F3_HU: begin
        lanes = 4'b0011 << off;
        err   = we | off[0];
      end
      F3_W: begin
        lanes = 4'b1111;
        err   = (off != 2'b00);
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      lanes     = 4'b0000;
      is_signed = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Brief   : Load/store initiator for dmem; sub-word stores use read-modify-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [3:0]  mem_wmem,
  output logic [4:0]  mem_rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data
);
  import lsu_pkg::*;

  lsu_state_e  state_q, state_d;
  logic [3:0]  lanes_q, lanes_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [3:0]  mem_wmem_q, mem_wmem_d;
  logic [4:0]  mem_rmem_q, mem_rmem_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_store_data_q, mem_store_data_d;

  logic [3:0]  dec_lanes;
  logic        dec_signed;
  logic        dec_err;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  lsu_lane_decode u_decode (
    .we        (req_we),
    .funct3    (req_funct3),
    .off       (req_addr[1:0]),
    .lanes     (dec_lanes),
    .is_signed (dec_signed),
    .err       (dec_err)
  );

  always_comb begin
    state_d          = state_q;
    lanes_d          = lanes_q;
    off_d            = off_q;
    wdata_d          = wdata_q;
    mem_addr_d       = mem_addr_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = 32'h0;
    mem_wmem_d       = WMEM_NONE;
    mem_rmem_d       = RMEM_NONE;
    mem_store_data_d = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lanes_d    = dec_lanes;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
          if (dec_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d    = S_LOAD;
            mem_rmem_d = {dec_signed, dec_lanes};
          end else if (dec_lanes == 4'b1111) begin
            state_d          = S_STORE;
            mem_wmem_d       = WMEM_WORD;
            mem_store_data_d = req_wdata;
          end else begin
            state_d    = S_RMW_RD;
            mem_rmem_d = RMEM_WORD;
          end
        end
      end
      S_LOAD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_load_data;
      end
      // Full-word rewrite because dmem zero-fills lanes not named in wmem.
      S_RMW_RD: begin
        state_d          = S_RMW_WR;
        mem_wmem_d       = WMEM_WORD;
        mem_store_data_d = merge_word(mem_load_data, wdata_q, lanes_q, off_q);
      end
      S_RMW_WR, S_STORE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      lanes_q          <= 4'b0000;
      off_q            <= 2'b00;
      wdata_q          <= 32'h0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0;
      mem_wmem_q       <= WMEM_NONE;
      mem_rmem_q       <= RMEM_NONE;
      mem_addr_q       <= 32'h0;
      mem_store_data_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      lanes_q          <= lanes_d;
      off_q            <= off_d;
      wdata_q          <= wdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_wmem_q       <= mem_wmem_d;
      mem_rmem_q       <= mem_rmem_d;
      mem_addr_q       <= mem_addr_d;
      mem_store_data_q <= mem_store_data_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_wmem       = mem_wmem_q;
  assign mem_rmem       = mem_rmem_q;
  assign mem_addr       = mem_addr_q;
  assign mem_store_data = mem_store_data_q;

endmodule

`default_nettype wire
